// File: rtl/apb_reg_slave.sv
// APB3 register slave: CTRL (programmable wait states), STATUS (saturating
// read/write counters) and scratch registers, with abort and error handling.
`timescale 1ns/1ps

module apb_reg_slave #(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [3:0]  ctrl_wait;
  logic [2:0]  idx;
  logic        legal;
  logic        wr;
  logic [15:0] wr_cnt, rd_cnt;
  logic [31:0] regs [8];

  logic        setup;
  logic        bad_addr;
  logic        complete;
  logic        err;
  logic [31:0] rd_val;

  assign setup    = (state == S_IDLE) && psel_i && !penable_i;
  assign bad_addr = (paddr_i[1:0] != 2'b00) || (paddr_i[31:5] != '0) ||
                    (32'(paddr_i[4:2]) >= NUM_REGS);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= S_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    complete   = 1'b0;
    case (state)
      S_IDLE: begin
        if (setup) state_next = (ctrl_wait != '0) ? S_WAIT : S_ACCESS;
      end
      S_WAIT: begin
        if (!psel_i)            state_next = S_IDLE;
        else if (cnt <= 4'd1)   state_next = S_ACCESS;
      end
      S_ACCESS: begin
        complete   = psel_i && penable_i;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Error is decided on the address latched in setup, not the live bus.
  assign err = !legal || (wr && (idx == 3'd1));

  always_comb begin
    rd_val = '0;
    case (idx)
      3'd0:    rd_val = {28'b0, ctrl_wait};
      3'd1:    rd_val = {rd_cnt, wr_cnt};
      default: rd_val = regs[idx];
    endcase
  end

  assign pready_o  = complete;
  assign pslverr_o = complete && err;
  assign prdata_o  = (complete && !wr && !err) ? rd_val : '0;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt       <= '0;
      idx       <= '0;
      legal     <= 1'b0;
      wr        <= 1'b0;
      ctrl_wait <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (setup) begin
        idx   <= paddr_i[4:2];
        legal <= !bad_addr;
        wr    <= pwrite_i;
        cnt   <= ctrl_wait;
      end else if (state == S_WAIT && psel_i) begin
        cnt <= cnt - 4'd1;
      end

      if (complete && !err) begin
        if (wr) begin
          if (idx == 3'd0) ctrl_wait <= pwdata_i[3:0];
          else             regs[idx] <= pwdata_i;
          if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
        end else begin
          if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: timing, register map, errors, abort,
// asynchronous reset and counter saturation.
`timescale 1ns/1ps

module tb_apb_reg_slave;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_wr = '0;
  logic [15:0] m_rd = '0;

  always #5 pclk = ~pclk;

  apb_reg_slave #(.NUM_REGS(8)) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .psel_i    (psel),
    .penable_i (penable),
    .paddr_i   (paddr),
    .pwrite_i  (pwrite),
    .pwdata_i  (pwdata),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] addr, input logic w, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int cyc);
    logic done;
    done = 1'b0;
    rd   = '0;
    er   = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = w; pwdata = wd;
    cyc = 1;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 2;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge pclk);
      if (pready) begin
        rd   = prdata;
        er   = pslverr;
        done = 1'b1;
      end else begin
        @(posedge pclk); #1;
        cyc++;
      end
    end
    check("xfer completed", {31'b0, done}, 32'd1);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic exp_err, input int exp_cyc);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    xfer(addr, 1'b1, data, rd, er, cyc);
    check({tag, " pslverr"}, {31'b0, er}, {31'b0, exp_err});
    check({tag, " cycles"}, cyc, exp_cyc);
    check({tag, " prdata"}, rd, 32'h0);
    if (!exp_err && m_wr != 16'hFFFF) m_wr++;
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err, input int exp_cyc);
    logic [31:0] rd;
    logic        er;
    int          cyc;
    xfer(addr, 1'b0, 32'h0, rd, er, cyc);
    check({tag, " pslverr"}, {31'b0, er}, {31'b0, exp_err});
    check({tag, " cycles"}, cyc, exp_cyc);
    check({tag, " prdata"}, rd, exp_data);
    if (!exp_err && m_rd != 16'hFFFF) m_rd++;
  endtask

  task automatic bus_idle();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " pready"}, {31'b0, pready}, 32'h0);
    check({tag, " pslverr"}, {31'b0, pslverr}, 32'h0);
    check({tag, " prdata"}, prdata, 32'h0);
  endtask

  initial begin
    // Reset, including a setup presented while reset is held
    #12;
    check_outputs_zero("in reset");
    psel = 1'b1;
    #10;
    check_outputs_zero("in reset with psel");
    psel = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;

    // Basic write/read and STATUS
    do_write("wr 0x08", 32'h08, 32'hDEADBEEF, 1'b0, 2);
    do_read ("rd 0x08", 32'h08, 32'hDEADBEEF, 1'b0, 2);
    do_read ("rd status", 32'h04, 32'h0001_0001, 1'b0, 2);
    do_read ("rd ctrl rst", 32'h00, 32'h0, 1'b0, 2);
    do_read ("rd 0x1C rst", 32'h1C, 32'h0, 1'b0, 2);
    do_write("wr 0x1C", 32'h1C, 32'h12345678, 1'b0, 2);
    do_read ("rd 0x1C", 32'h1C, 32'h12345678, 1'b0, 2);

    // CTRL write takes effect from the next setup only
    do_write("wr ctrl 3", 32'h00, 32'hA5A5_A5A3, 1'b0, 2);
    do_read ("rd 0x0C wait3", 32'h0C, 32'h0, 1'b0, 5);
    do_read ("rd ctrl", 32'h00, 32'h3, 1'b0, 5);

    // Error responses
    do_write("wr status", 32'h04, 32'hFFFF_FFFF, 1'b1, 5);
    do_write("wr 0x20", 32'h20, 32'h1111_2222, 1'b1, 5);
    do_write("wr 0x09", 32'h09, 32'h3333_4444, 1'b1, 5);
    do_read ("rd 0x20", 32'h20, 32'h0, 1'b1, 5);
    do_read ("rd 0x08 kept", 32'h08, 32'hDEADBEEF, 1'b0, 5);
    do_read ("rd status err", 32'h04, {m_rd, m_wr}, 1'b0, 5);

    // Abort during WAIT with WAIT=5
    do_write("wr ctrl 5", 32'h00, 32'h5, 1'b0, 5);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hCAFEF00D;
    @(negedge pclk);
    check("abort setup pready", {31'b0, pready}, 32'h0);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("abort wait1 pready", {31'b0, pready}, 32'h0);
    @(posedge pclk); #1;
    @(negedge pclk);
    check("abort wait2 pready", {31'b0, pready}, 32'h0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      check("abort after pready", {31'b0, pready}, 32'h0);
    end
    do_read ("rd 0x10 abort", 32'h10, 32'h0, 1'b0, 7);
    do_read ("rd status abort", 32'h04, {m_rd, m_wr}, 1'b0, 7);

    // Reset during WAIT of a write to 0x08
    do_write("wr ctrl 2", 32'h00, 32'h2, 1'b0, 7);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h1111_1111;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("rst wait pready", {31'b0, pready}, 32'h0);
    #1 preset_n = 1'b0;
    #1 check_outputs_zero("rst in wait");
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    m_wr = '0; m_rd = '0;
    do_read ("rd 0x08 after rst", 32'h08, 32'h0, 1'b0, 2);
    do_read ("rd ctrl after rst", 32'h00, 32'h0, 1'b0, 2);
    do_read ("rd status after rst", 32'h04, 32'h0002_0000, 1'b0, 2);

    // Reset during the completion cycle: pready drops at once, no commit
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h2222_2222;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("rst access pready", {31'b0, pready}, 32'h1);
    #1 preset_n = 1'b0;
    #1 check_outputs_zero("rst in access");
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    m_wr = '0; m_rd = '0;
    do_read ("rd 0x08 no commit", 32'h08, 32'h0, 1'b0, 2);

    // WR_CNT saturation, pre-loaded near the limit
    bus_idle();
    force dut.wr_cnt = 16'hFFFD;
    #1 release dut.wr_cnt;
    m_wr = 16'hFFFD;
    do_read ("rd status preload", 32'h04, {m_rd, 16'hFFFD}, 1'b0, 2);
    do_write("wr sat 1", 32'h14, 32'h1, 1'b0, 2);
    do_write("wr sat 2", 32'h14, 32'h2, 1'b0, 2);
    do_write("wr sat 3", 32'h14, 32'h3, 1'b0, 2);
    do_read ("rd status sat", 32'h04, {m_rd, 16'hFFFF}, 1'b0, 2);

    // penable without a preceding setup is ignored
    do_write("wr 0x08 pre", 32'h08, 32'h5555_AAAA, 1'b0, 2);
    bus_idle();
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check("penable only pready", {31'b0, pready}, 32'h0);
    @(posedge pclk); #1;
    psel = 1'b1; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h0000_0099;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("no setup pready", {31'b0, pready}, 32'h0);
    end
    bus_idle();
    do_read ("rd 0x08 ignored", 32'h08, 32'h5555_AAAA, 1'b0, 2);
    do_read ("rd status ignored", 32'h04, {m_rd, m_wr}, 1'b0, 2);
    bus_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
